// File: rtl/snake_body_engine.sv
// Snake body engine: keeps the snake body in a circular buffer, advances it on step
// pulses, detects wall/self collision and issues erase-tail / draw-head pixel requests.
// Optional feature: define SNAKE_WRAP_EN for a toroidal playfield (walls never kill).
module snake_body_engine #(
  parameter int H_LOGIC_WIDTH  = 5,
  parameter int V_LOGIC_WIDTH  = 5,
  parameter int H_LOGIC_MAX    = 31,
  parameter int V_LOGIC_MAX    = 23,
  parameter int MAX_LEN        = 64,
  parameter int LEN_WIDTH      = 7,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int START_X        = 16,
  parameter int START_Y        = 12,
  parameter logic [COLOR_ID_WIDTH-1:0] HEAD_COLOR = 8'hff,
  parameter logic [COLOR_ID_WIDTH-1:0] BG_COLOR   = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step,
  input  logic [3:0]                way,
  input  logic                      grow,
  output logic [H_LOGIC_WIDTH-1:0]  px_x,
  output logic [V_LOGIC_WIDTH-1:0]  px_y,
  output logic [COLOR_ID_WIDTH-1:0] px_color,
  output logic                      px_vld,
  input  logic                      px_done,
  output logic [H_LOGIC_WIDTH-1:0]  head_x,
  output logic [V_LOGIC_WIDTH-1:0]  head_y,
  output logic [LEN_WIDTH-1:0]      length,
  output logic                      busy,
  output logic                      game_over
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [H_LOGIC_WIDTH-1:0] X_MAX   = H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_MAX   = V_LOGIC_WIDTH'(V_LOGIC_MAX);
  localparam logic [H_LOGIC_WIDTH-1:0] X_START = H_LOGIC_WIDTH'(START_X);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_START = V_LOGIC_WIDTH'(START_Y);
  localparam logic [LEN_WIDTH-1:0]     LEN_MAX = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE = LEN_WIDTH'(1);
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(MAX_LEN - 1);
  localparam logic [PTR_W:0]           PTR_MOD  = (PTR_W+1)'(MAX_LEN);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_INIT,
    S_IDLE,
    S_CALC,
    S_CHECK,
    S_ERASE,
    S_HEAD,
    S_DEAD
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            head_ptr_q, head_ptr_d;
  logic [LEN_WIDTH-1:0]        length_q, length_d;
  logic [3:0]                  dir_q, dir_d;
  logic                        grow_pend_q, grow_pend_d;
  logic                        game_over_q, game_over_d;
  logic                        px_vld_q, px_vld_d;
  logic [H_LOGIC_WIDTH-1:0]    px_x_q, px_x_d;
  logic [V_LOGIC_WIDTH-1:0]    px_y_q, px_y_d;
  logic [COLOR_ID_WIDTH-1:0]   px_color_q, px_color_d;
  logic [H_LOGIC_WIDTH-1:0]    head_x_q, head_x_d;
  logic [V_LOGIC_WIDTH-1:0]    head_y_q, head_y_d;
  logic [H_LOGIC_WIDTH-1:0]    next_x_q, next_x_d;
  logic [V_LOGIC_WIDTH-1:0]    next_y_q, next_y_d;
  logic                        eff_grow_q, eff_grow_d;
  logic [LEN_WIDTH-1:0]        chk_cnt_q, chk_cnt_d;
  logic [PTR_W-1:0]            chk_idx_q, chk_idx_d;

  logic [H_LOGIC_WIDTH-1:0]    body_x [MAX_LEN];
  logic [V_LOGIC_WIDTH-1:0]    body_y [MAX_LEN];
  logic                        buf_we;
  logic [PTR_W-1:0]            buf_widx;
  logic [H_LOGIC_WIDTH-1:0]    buf_wx;
  logic [V_LOGIC_WIDTH-1:0]    buf_wy;

  logic [PTR_W-1:0]            head_ptr_inc;
  logic [PTR_W:0]              tail_sum;
  logic [PTR_W-1:0]            tail_idx;
  logic                        way_ok;
  logic [3:0]                  dir_rev, dir_new;
  logic                        at_edge, cand_wall;
  logic [H_LOGIC_WIDTH-1:0]    cand_x;
  logic [V_LOGIC_WIDTH-1:0]    cand_y;
  logic                        eg;
  logic [LEN_WIDTH-1:0]        chk_n;
  logic                        hit;
  logic                        launch_erase, launch_head;

  assign head_ptr_inc = ptr_inc(head_ptr_q);

  // Tail sits length-1 entries behind the head; the +MAX_LEN bias keeps the sum non-negative.
  always_comb begin
    tail_sum = {1'b0, head_ptr_q} + PTR_MOD - (PTR_W+1)'(length_q) + (PTR_W+1)'(1);
    tail_idx = (tail_sum >= PTR_MOD) ? PTR_W'(tail_sum - PTR_MOD) : PTR_W'(tail_sum);
  end

  // Direction filter and candidate next head.
  always_comb begin
    way_ok  = (way == 4'b0001) || (way == 4'b0010) || (way == 4'b0100) || (way == 4'b1000);
    dir_rev = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    dir_new = dir_q;
    if (way_ok && !((length_q > LEN_ONE) && (way == dir_rev))) dir_new = way;

    cand_x  = head_x_q;
    cand_y  = head_y_q;
    at_edge = 1'b0;
    if (dir_new[0]) begin
      at_edge = (head_x_q == X_MAX);
      cand_x  = at_edge ? '0 : head_x_q + 1'b1;
    end else if (dir_new[1]) begin
      at_edge = (head_x_q == '0);
      cand_x  = at_edge ? X_MAX : head_x_q - 1'b1;
    end else if (dir_new[2]) begin
      at_edge = (head_y_q == Y_MAX);
      cand_y  = at_edge ? '0 : head_y_q + 1'b1;
    end else begin
      at_edge = (head_y_q == '0);
      cand_y  = at_edge ? Y_MAX : head_y_q - 1'b1;
    end
`ifdef SNAKE_WRAP_EN
    cand_wall = 1'b0;
`else
    cand_wall = at_edge;
`endif
  end

  // NOTE: every signal written in an always_comb is given a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    head_ptr_d   = head_ptr_q;
    length_d     = length_q;
    dir_d        = dir_q;
    grow_pend_d  = grow_pend_q;
    game_over_d  = game_over_q;
    px_vld_d     = 1'b0;
    px_x_d       = px_x_q;
    px_y_d       = px_y_q;
    px_color_d   = px_color_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    next_x_d     = next_x_q;
    next_y_d     = next_y_q;
    eff_grow_d   = eff_grow_q;
    chk_cnt_d    = chk_cnt_q;
    chk_idx_d    = chk_idx_q;
    buf_we       = 1'b0;
    buf_widx     = head_ptr_inc;
    buf_wx       = next_x_q;
    buf_wy       = next_y_q;
    launch_erase = 1'b0;
    launch_head  = 1'b0;

    eg    = grow_pend_q && (length_q < LEN_MAX);
    chk_n = eg ? length_q : length_q - LEN_ONE;
    hit   = (body_x[chk_idx_q] == next_x_q) && (body_y[chk_idx_q] == next_y_q);

    case (state_q)
      S_INIT: begin
        buf_we     = 1'b1;
        buf_widx   = '0;
        buf_wx     = X_START;
        buf_wy     = Y_START;
        px_vld_d   = 1'b1;
        px_x_d     = X_START;
        px_y_d     = Y_START;
        px_color_d = HEAD_COLOR;
        state_d    = S_WAIT_INIT;
      end
      S_WAIT_INIT: if (px_done) state_d = S_IDLE;
      S_IDLE:      if (step) state_d = S_CALC;
      S_CALC: begin
        dir_d      = dir_new;
        next_x_d   = cand_x;
        next_y_d   = cand_y;
        eff_grow_d = eg;
        chk_cnt_d  = chk_n;
        chk_idx_d  = head_ptr_q;
        if (grow_pend_q && !eg) grow_pend_d = 1'b0;
        if (cand_wall)           state_d = S_DEAD;
        else if (chk_n == '0)    launch_erase = 1'b1;
        else                     state_d = S_CHECK;
      end
      S_CHECK: begin
        chk_cnt_d = chk_cnt_q - LEN_ONE;
        chk_idx_d = ptr_dec(chk_idx_q);
        if (hit) begin
          state_d = S_DEAD;
        end else if (chk_cnt_q == LEN_ONE) begin
          if (eff_grow_q) launch_head  = 1'b1;
          else            launch_erase = 1'b1;
        end
      end
      S_ERASE: if (px_done) launch_head = 1'b1;
      S_HEAD:  if (px_done) state_d = S_IDLE;
      S_DEAD:  ;
      default: state_d = S_INIT;
    endcase

    if (launch_erase) begin
      px_vld_d   = 1'b1;
      px_x_d     = body_x[tail_idx];
      px_y_d     = body_y[tail_idx];
      px_color_d = BG_COLOR;
      state_d    = S_ERASE;
    end

    // Head commit: buffer write, pointer, head and length all move on the same edge.
    if (launch_head) begin
      buf_we      = 1'b1;
      head_ptr_d  = head_ptr_inc;
      head_x_d    = next_x_q;
      head_y_d    = next_y_q;
      length_d    = length_q + (eff_grow_q ? LEN_ONE : '0);
      grow_pend_d = 1'b0;
      px_vld_d    = 1'b1;
      px_x_d      = next_x_q;
      px_y_d      = next_y_q;
      px_color_d  = HEAD_COLOR;
      state_d     = S_HEAD;
    end

    if (grow && (state_q != S_DEAD)) grow_pend_d = 1'b1;
    if (state_d == S_DEAD) game_over_d = 1'b1;
  end

  // NOTE: the body buffer is not reset; INIT writes entry 0 before anything reads it.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      body_x[buf_widx] <= buf_wx;
      body_y[buf_widx] <= buf_wy;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      head_ptr_q  <= '0;
      length_q    <= LEN_ONE;
      dir_q       <= 4'b0001;
      grow_pend_q <= 1'b0;
      game_over_q <= 1'b0;
      px_vld_q    <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      px_color_q  <= '0;
      head_x_q    <= X_START;
      head_y_q    <= Y_START;
      next_x_q    <= '0;
      next_y_q    <= '0;
      eff_grow_q  <= 1'b0;
      chk_cnt_q   <= '0;
      chk_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_ptr_q  <= head_ptr_d;
      length_q    <= length_d;
      dir_q       <= dir_d;
      grow_pend_q <= grow_pend_d;
      game_over_q <= game_over_d;
      px_vld_q    <= px_vld_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      px_color_q  <= px_color_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      next_x_q    <= next_x_d;
      next_y_q    <= next_y_d;
      eff_grow_q  <= eff_grow_d;
      chk_cnt_q   <= chk_cnt_d;
      chk_idx_q   <= chk_idx_d;
    end
  end

  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign px_color  = px_color_q;
  assign px_vld    = px_vld_q;
  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = length_q;
  assign game_over = game_over_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DEAD);

endmodule
